// File: rtl/vote_result_scanner.sv
// vote_result_scanner
// Snapshots four candidate tallies on entry to result mode. It then scans the
// snapshot one candidate per cycle and publishes a held, registered result.
//
// Ports:
//   clock, reset       rising-edge clock; asynchronous active-low reset
//   mode               0 = voting, 1 = result mode (0->1 starts a scan)
//   cand1..4_vote      live per-candidate tallies (sampled only at scan start)
//   busy               scan in progress
//   result_valid       published result belongs to the current result session
//   winner_id          0..3 = candidate 1..4 (lowest index wins ties)
//   winner_votes       tally of the winner
//   tie                two or more candidates share the maximum
//   no_votes           grand total is zero
//   total_votes        sum of all four tallies
module vote_result_scanner #(
   parameter int unsigned NUM_CAND = 4,
   parameter int unsigned CNT_W    = 8,
   parameter int unsigned TOT_W    = 10
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             mode,
   input  logic [CNT_W-1:0] cand1_vote,
   input  logic [CNT_W-1:0] cand2_vote,
   input  logic [CNT_W-1:0] cand3_vote,
   input  logic [CNT_W-1:0] cand4_vote,
   output logic             busy,
   output logic             result_valid,
   output logic [1:0]       winner_id,
   output logic [CNT_W-1:0] winner_votes,
   output logic             tie,
   output logic             no_votes,
   output logic [TOT_W-1:0] total_votes
);

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

   state_e           state_q, state_d;
   logic             mode_q;
   logic [1:0]       idx_q, idx_d;
   logic [CNT_W-1:0] snap_q [NUM_CAND];
   logic [CNT_W-1:0] snap_d [NUM_CAND];
   logic [CNT_W-1:0] best_q, best_d;
   logic [1:0]       best_id_q, best_id_d;
   logic             tie_w_q, tie_w_d;
   logic [TOT_W-1:0] sum_q, sum_d;

   logic             busy_q, busy_d;
   logic             valid_q, valid_d;
   logic [1:0]       win_id_q, win_id_d;
   logic [CNT_W-1:0] win_votes_q, win_votes_d;
   logic             tie_q, tie_d;
   logic             no_votes_q, no_votes_d;
   logic [TOT_W-1:0] total_q, total_d;

   logic             start, stop;
   logic [CNT_W-1:0] cur;
   logic [CNT_W-1:0] step_best;
   logic [1:0]       step_id;
   logic             step_tie;
   logic [TOT_W-1:0] step_sum;

   assign start = mode & ~mode_q;
   assign stop  = ~mode;
   assign cur   = snap_q[idx_q];

   // One scan step: candidate idx against the running best. Strict '>' keeps
   // the lower index on equal counts.
   always_comb begin
      step_best = best_q;
      step_id   = best_id_q;
      step_tie  = tie_w_q;
      step_sum  = sum_q + TOT_W'(cur);
      if (idx_q == 2'd0) begin
         step_best = cur;
         step_id   = 2'd0;
         step_tie  = 1'b0;
         step_sum  = TOT_W'(cur);
      end else if (cur > best_q) begin
         step_best = cur;
         step_id   = idx_q;
         step_tie  = 1'b0;
      end else if (cur == best_q) begin
         step_tie  = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      snap_d      = snap_q;
      best_d      = best_q;
      best_id_d   = best_id_q;
      tie_w_d     = tie_w_q;
      sum_d       = sum_q;
      valid_d     = valid_q;
      win_id_d    = win_id_q;
      win_votes_d = win_votes_q;
      tie_d       = tie_q;
      no_votes_d  = no_votes_q;
      total_d     = total_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               snap_d[0] = cand1_vote;
               snap_d[1] = cand2_vote;
               snap_d[2] = cand3_vote;
               snap_d[3] = cand4_vote;
               idx_d     = 2'd0;
               state_d   = StScan;
            end
         end
         StScan: begin
            if (stop) begin
               // Abort: published outputs keep their previous values.
               state_d = StIdle;
            end else begin
               best_d    = step_best;
               best_id_d = step_id;
               tie_w_d   = step_tie;
               sum_d     = step_sum;
               idx_d     = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  win_id_d    = step_id;
                  win_votes_d = step_best;
                  tie_d       = step_tie;
                  no_votes_d  = (step_sum == '0);
                  total_d     = step_sum;
                  valid_d     = 1'b1;
                  state_d     = StDone;
               end
            end
         end
         StDone: begin
            if (stop) begin
               valid_d = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      busy_d = (state_d == StScan);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         mode_q      <= 1'b0;
         idx_q       <= 2'd0;
         for (int i = 0; i < NUM_CAND; i++) snap_q[i] <= '0;
         best_q      <= '0;
         best_id_q   <= 2'd0;
         tie_w_q     <= 1'b0;
         sum_q       <= '0;
         busy_q      <= 1'b0;
         valid_q     <= 1'b0;
         win_id_q    <= 2'd0;
         win_votes_q <= '0;
         tie_q       <= 1'b0;
         no_votes_q  <= 1'b0;
         total_q     <= '0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode;
         idx_q       <= idx_d;
         snap_q      <= snap_d;
         best_q      <= best_d;
         best_id_q   <= best_id_d;
         tie_w_q     <= tie_w_d;
         sum_q       <= sum_d;
         busy_q      <= busy_d;
         valid_q     <= valid_d;
         win_id_q    <= win_id_d;
         win_votes_q <= win_votes_d;
         tie_q       <= tie_d;
         no_votes_q  <= no_votes_d;
         total_q     <= total_d;
      end
   end

   assign busy         = busy_q;
   assign result_valid = valid_q;
   assign winner_id    = win_id_q;
   assign winner_votes = win_votes_q;
   assign tie          = tie_q;
   assign no_votes     = no_votes_q;
   assign total_votes  = total_q;

endmodule

// File: tb/tb_vote_result_scanner.sv
// Bench for vote_result_scanner: expected results are pushed to a scoreboard
// when a scan is launched and popped when result_valid rises.
module tb_vote_result_scanner;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       mode  = 1'b0;
   logic [7:0] c1 = 8'd0, c2 = 8'd0, c3 = 8'd0, c4 = 8'd0;
   logic       busy, result_valid, tie, no_votes;
   logic [1:0] winner_id;
   logic [7:0] winner_votes;
   logic [9:0] total_votes;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] votes;
      logic       tie;
      logic       nov;
      logic [9:0] total;
   } exp_t;

   exp_t sb[$];

   always #5 clock = ~clock;

   vote_result_scanner #(.NUM_CAND(4), .CNT_W(8), .TOT_W(10)) dut (
      .clock        (clock),
      .reset        (reset),
      .mode         (mode),
      .cand1_vote   (c1),
      .cand2_vote   (c2),
      .cand3_vote   (c3),
      .cand4_vote   (c4),
      .busy         (busy),
      .result_valid (result_valid),
      .winner_id    (winner_id),
      .winner_votes (winner_votes),
      .tie          (tie),
      .no_votes     (no_votes),
      .total_votes  (total_votes)
   );

   function automatic exp_t model(input logic [7:0] a, b, c, d);
      logic [7:0] t [4];
      exp_t e;
      int   n;
      t[0] = a; t[1] = b; t[2] = c; t[3] = d;
      e.votes = t[0];
      e.id    = 2'd0;
      for (int i = 1; i < 4; i++)
         if (t[i] > e.votes) begin
            e.votes = t[i];
            e.id    = 2'(i);
         end
      n = 0;
      e.total = '0;
      for (int i = 0; i < 4; i++) begin
         if (t[i] == e.votes) n++;
         e.total = e.total + 10'(t[i]);
      end
      e.tie = (n >= 2);
      e.nov = (e.total == 10'd0);
      return e;
   endfunction

   // Leave result mode for one edge, load tallies, push expectation, raise mode.
   task automatic start_scan(input logic [7:0] a, b, c, d);
      @(negedge clock);
      mode = 1'b0;
      @(negedge clock);
      c1 = a; c2 = b; c3 = c; c4 = d;
      sb.push_back(model(a, b, c, d));
      mode = 1'b1;
   endtask

   task automatic collect_result(input string name, input int pre_busy);
      int   busy_cnt = pre_busy;
      bit   got = 1'b0;
      exp_t e;
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         if (result_valid) begin
            got = 1'b1;
            break;
         end
         if (busy) busy_cnt++;
      end
      checks++;
      if (!got || sb.size() == 0) begin
         failures++;
         $display("FAIL %s timeout: result_valid got 0 want 1 (sb=%0d)", name, sb.size());
         return;
      end
      e = sb.pop_front();
      checks++;
      if (busy_cnt != 4) begin
         failures++;
         $display("FAIL %s busy_cycles: got %0d want 4", name, busy_cnt);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL %s busy_after: got %b want 0", name, busy);
      end
      checks++;
      if (winner_id !== e.id) begin
         failures++;
         $display("FAIL %s winner_id: got %0d want %0d", name, winner_id, e.id);
      end
      checks++;
      if (winner_votes !== e.votes) begin
         failures++;
         $display("FAIL %s winner_votes: got %0d want %0d", name, winner_votes, e.votes);
      end
      checks++;
      if (tie !== e.tie) begin
         failures++;
         $display("FAIL %s tie: got %b want %b", name, tie, e.tie);
      end
      checks++;
      if (no_votes !== e.nov) begin
         failures++;
         $display("FAIL %s no_votes: got %b want %b", name, no_votes, e.nov);
      end
      checks++;
      if (total_votes !== e.total) begin
         failures++;
         $display("FAIL %s total_votes: got %0d want %0d", name, total_votes, e.total);
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({busy, result_valid, winner_id, winner_votes, tie, no_votes, total_votes} !== '0) begin
         failures++;
         $display("FAIL reset_state: got b%b v%b id%0d w%0d t%b n%b tot%0d want all 0",
                  busy, result_valid, winner_id, winner_votes, tie, no_votes, total_votes);
      end
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_basic();
      start_scan(8'd5, 8'd9, 8'd3, 8'd7);
      collect_result("basic", 0);
      // Expected values also pinned directly from the worked example.
      checks++;
      if (winner_id !== 2'd1 || total_votes !== 10'd24 || result_valid !== 1'b1) begin
         failures++;
         $display("FAIL basic_fixed: got id%0d tot%0d v%b want id1 tot24 v1",
                  winner_id, total_votes, result_valid);
      end
   endtask

   task automatic test_tie();
      start_scan(8'd6, 8'd2, 8'd6, 8'd1);
      collect_result("tie", 0);
   endtask

   task automatic test_zero();
      start_scan(8'd0, 8'd0, 8'd0, 8'd0);
      collect_result("zero", 0);
   endtask

   task automatic test_max();
      start_scan(8'd255, 8'd255, 8'd255, 8'd255);
      collect_result("max", 0);
      checks++;
      if (total_votes !== 10'd1020) begin
         failures++;
         $display("FAIL max_nowrap: got %0d want 1020", total_votes);
      end
   endtask

   task automatic test_rescan();
      int bc = 0;
      start_scan(8'd5, 8'd9, 8'd3, 8'd7);
      collect_result("rescan_first", 0);
      start_scan(8'd1, 8'd1, 8'd1, 8'd8);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         if (busy) bc++;
         checks++;
         if (result_valid !== 1'b0 || winner_id !== 2'd1 || winner_votes !== 8'd9) begin
            failures++;
            $display("FAIL rescan_hold[%0d]: got v%b id%0d w%0d want v0 id1 w9",
                     i, result_valid, winner_id, winner_votes);
         end
      end
      collect_result("rescan_second", bc);
   endtask

   task automatic test_abort();
      @(negedge clock);
      mode = 1'b0;
      @(negedge clock);
      c1 = 8'd20; c2 = 8'd0; c3 = 8'd0; c4 = 8'd0;
      mode = 1'b1;
      @(negedge clock);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL abort_busy_e0: got %b want 1", busy);
      end
      @(negedge clock);
      mode = 1'b0;
      @(negedge clock);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (busy !== 1'b0 || result_valid !== 1'b0 || winner_id !== 2'd3 ||
             winner_votes !== 8'd8 || total_votes !== 10'd11) begin
            failures++;
            $display("FAIL abort_hold[%0d]: got b%b v%b id%0d w%0d tot%0d want b0 v0 id3 w8 tot11",
                     i, busy, result_valid, winner_id, winner_votes, total_votes);
         end
         @(negedge clock);
      end
   endtask

   task automatic test_reset_mid_scan();
      @(negedge clock);
      c1 = 8'd9; c2 = 8'd9; c3 = 8'd0; c4 = 8'd0;
      mode = 1'b1;
      @(negedge clock);
      @(negedge clock);
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({busy, result_valid, winner_id, winner_votes, tie, no_votes, total_votes} !== '0) begin
         failures++;
         $display("FAIL reset_mid: got b%b v%b id%0d w%0d t%b n%b tot%0d want all 0",
                  busy, result_valid, winner_id, winner_votes, tie, no_votes, total_votes);
      end
      c1 = 8'd4; c2 = 8'd0; c3 = 8'd0; c4 = 8'd0;
      sb.push_back(model(8'd4, 8'd0, 8'd0, 8'd0));
      @(negedge clock);
      reset = 1'b1;
      collect_result("reset_restart", 0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_tie();
      test_zero();
      test_max();
      test_rescan();
      test_abort();
      test_reset_mid_scan();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
